// File: rtl/cache_refill_ctrl_pkg.sv
// rtl/cache_refill_ctrl_pkg.sv - shared constants, AXI encodings and FSM states for the refill engine
package cache_refill_ctrl_pkg;

  localparam int LINE_WORDS_DEF  = 16;
  localparam int CACHELINE_WIDTH = LINE_WORDS_DEF * 32;
  localparam int TAG_WIDTH       = 20;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

  typedef enum logic [3:0] {
    IDLE,
    WB_RD,
    WB_CAP,
    AW,
    W,
    B,
    AR,
    R,
    FILL
  } state_t;

endpackage

// File: rtl/cache_refill_ctrl_line_buffer.sv
// rtl/cache_refill_ctrl_line_buffer.sv - line_buffer_512: word-writable register array with parallel line load and read
module line_buffer_512
  import cache_refill_ctrl_pkg::*;
#(
  parameter int WORDS = LINE_WORDS_DEF,
  localparam int IDX_W = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [WORDS*32-1:0]   load_line,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [31:0]           wr_data,
  output logic [WORDS*32-1:0]   line
);

  logic [31:0] mem [WORDS];

  // Whole-line load has priority over a single-word write; both never coincide in use.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= load_line[i*32 +: 32];
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  for (genvar g = 0; g < WORDS; g++) begin : g_line
    assign line[g*32 +: 32] = mem[g];
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - miss engine: optional victim write-back, line refill burst, one-cycle refresh (option: CACHE_CRITICAL_WORD_FIRST_EN)
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int         LINE_WORDS = LINE_WORDS_DEF,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     miss,
  input  logic                     dirty,
  input  logic [31:0]              miss_addr,
  input  logic [TAG_WIDTH-1:0]     victim_tag,
  output logic                     write_back,
  input  logic [LINE_WORDS*32-1:0] cacheline_old,
  output logic                     refresh,
  output logic [LINE_WORDS*32-1:0] cacheline_new,
  output logic                     stall,
  output logic [3:0]               arid,
  output logic [31:0]              araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [31:0]              rdata,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [3:0]               awid,
  output logic [31:0]              awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic                     bvalid,
  output logic                     bready
);

  localparam int                LINE_BITS = LINE_WORDS * 32;
  localparam int                CNT_W     = $clog2(LINE_WORDS);
  localparam int                OFF_W     = CNT_W + 2;
  localparam logic [7:0]        BURST_LEN = 8'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       start_idx;
  logic [31:0]            addr_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic                   post_fill;
  logic                   accept;
  logic [31:0]            victim_addr;
  logic [31:0]            fill_addr;
  logic [1:0]             fill_burst;
  logic [LINE_BITS-1:0]   wb_line;
  logic [LINE_BITS-1:0]   fill_line;
  logic [31:0]            wb_words [LINE_WORDS];
  logic                   unused_addr_bits;

  // post_fill blocks acceptance in the cycle right after FILL, when the
  // requester may still show the old miss before its re-lookup hits.
  assign accept      = resetn && (state == IDLE) && miss && !post_fill;
  assign victim_addr = {tag_q, addr_q[11:OFF_W], {OFF_W{1'b0}}};

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  assign fill_addr        = {addr_q[31:2], 2'b00};
  assign fill_burst       = AXI_BURST_WRAP;
  assign start_idx        = addr_q[OFF_W-1:2];
  assign unused_addr_bits = ^addr_q[1:0];
`else
  assign fill_addr        = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
  assign fill_burst       = AXI_BURST_INCR;
  assign start_idx        = '0;
  assign unused_addr_bits = ^addr_q[OFF_W-1:0];
`endif

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_wb_words
    assign wb_words[g] = wb_line[g*32 +: 32];
  end

  line_buffer_512 #(.WORDS(LINE_WORDS)) u_wb_buf (
    .clk       (clk),
    .resetn    (resetn),
    .load      (state == WB_CAP),
    .load_line (cacheline_old),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_data   ('0),
    .line      (wb_line)
  );

  line_buffer_512 #(.WORDS(LINE_WORDS)) u_fill_buf (
    .clk       (clk),
    .resetn    (resetn),
    .load      (1'b0),
    .load_line ('0),
    .wr_en     ((state == R) && rvalid),
    .wr_idx    (start_idx + cnt),
    .wr_data   (rdata),
    .line      (fill_line)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Request latching, beat counter and the post-fill acceptance guard.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      addr_q    <= '0;
      tag_q     <= '0;
      post_fill <= 1'b0;
    end else begin
      post_fill <= (state == FILL);
      if (accept) begin
        addr_q <= miss_addr;
        tag_q  <= victim_tag;
      end
      case (state)
        AW:      if (awready)           cnt <= '0;
        W:       if (wvalid && wready)  cnt <= cnt + 1'b1;
        AR:      if (arready)           cnt <= '0;
        R:       if (rvalid)            cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state and Moore outputs; every AXI valid comes from the state register.
  always_comb begin
    state_nxt     = state;
    write_back    = 1'b0;
    refresh       = 1'b0;
    cacheline_new = '0;
    stall         = accept || (state != IDLE);
    arid          = '0;
    araddr        = '0;
    arlen         = '0;
    arsize        = '0;
    arburst       = '0;
    arvalid       = 1'b0;
    rready        = 1'b0;
    awid          = '0;
    awaddr        = '0;
    awlen         = '0;
    awsize        = '0;
    awburst       = '0;
    awvalid       = 1'b0;
    wdata         = '0;
    wstrb         = '0;
    wlast         = 1'b0;
    wvalid        = 1'b0;
    bready        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = dirty ? WB_RD : AR;
      end
      WB_RD: begin
        write_back = 1'b1;
        state_nxt  = WB_CAP;
      end
      WB_CAP: begin
        state_nxt = AW;
      end
      AW: begin
        awvalid = 1'b1;
        awid    = AXI_ID;
        awaddr  = victim_addr;
        awlen   = BURST_LEN;
        awsize  = AXI_SIZE_WORD;
        awburst = AXI_BURST_INCR;
        if (awready) state_nxt = W;
      end
      W: begin
        wvalid = 1'b1;
        wdata  = wb_words[cnt];
        wstrb  = 4'hF;
        wlast  = (cnt == LAST_BEAT);
        if (wready && wlast) state_nxt = B;
      end
      B: begin
        bready = 1'b1;
        if (bvalid) state_nxt = AR;
      end
      AR: begin
        arvalid = 1'b1;
        arid    = AXI_ID;
        araddr  = fill_addr;
        arlen   = BURST_LEN;
        arsize  = AXI_SIZE_WORD;
        arburst = fill_burst;
        if (arready) state_nxt = R;
      end
      R: begin
        rready = 1'b1;
        if (rvalid && rlast) state_nxt = FILL;
      end
      FILL: begin
        refresh       = 1'b1;
        cacheline_new = fill_line;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
